// File: rtl/mmr_mem_router_pkg.sv
// Shared definitions for the CPU-port to MMR/memory router.
`ifndef MMR_MEM_ROUTER_PKG_SV
`define MMR_MEM_ROUTER_PKG_SV

// Select port idx's w-bit field from a port-packed vector (port 0 in the LSBs).
`define MMR_PORT_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package mmr_mem_router_pkg;

    localparam int unsigned DEF_MMR_PREFIX_BITS = 13;
    localparam int unsigned DEF_MMR_ADDR_W      = 8;
    localparam int unsigned TIMEOUT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MMR_ARB  = 3'd1,
        ST_MMR_WAIT = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_DONE     = 3'd4
    } port_state_e;

endpackage

`endif

// File: rtl/mmr_rr_arbiter.sv
// Round-robin arbiter for the single shared MMR bus, with a busy counter
// that blocks new grants while an access is still in flight.
module mmr_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt_c,
    output logic                 last_c
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             found;

    // Pointer and busy counter; pointer starts at the last port so port 0 leads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_W'(NUM_PORTS - 1);
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Grant the first requester after the pointer, only when the bus is idle.
    always_comb begin
        gnt_c = '0;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        found = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            for (int k = 1; k <= int'(NUM_PORTS); k++) begin
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    if (!found && req[i] && (i == ((int'(ptr_q) + k) % int'(NUM_PORTS)))) begin
                        found    = 1'b1;
                        gnt_c[i] = 1'b1;
                        ptr_d    = PTR_W'(i);
                    end
                end
            end
            if (found && (LATENCY > 1)) begin
                cnt_d = CNT_W'(LATENCY - 1);
            end
        end
    end

    // Final busy cycle of a multi-cycle access: read data is valid now.
    assign last_c = (LATENCY > 1) && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mmr_mem_router.sv
// Routes N CPU load/store ports to a shared MMR bank or per-port memory.
module mmr_mem_router
    import mmr_mem_router_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MMR_PREFIX_BITS = DEF_MMR_PREFIX_BITS,
    parameter int unsigned MMR_ADDR_W      = DEF_MMR_ADDR_W,
    parameter int unsigned MMR_LATENCY     = 1,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          cpu_req,
    input  logic [NUM_PORTS-1:0]          cpu_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   cpu_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   cpu_wdata,
    output logic [NUM_PORTS*DATA_W-1:0]   cpu_rdata,
    output logic [NUM_PORTS-1:0]          cpu_rda,
    output logic [NUM_PORTS-1:0]          cpu_err,
    output logic                          mmr_en,
    output logic                          mmr_we,
    output logic [MMR_ADDR_W-1:0]         mmr_addr,
    output logic [DATA_W-1:0]             mmr_wdata,
    input  logic [DATA_W-1:0]             mmr_rdata,
    output logic [NUM_PORTS-1:0]          mem_en,
    output logic [NUM_PORTS-1:0]          mem_we,
    output logic [NUM_PORTS*ADDR_W-1:0]   mem_addr,
    output logic [NUM_PORTS*DATA_W-1:0]   mem_wdata,
    input  logic [NUM_PORTS*DATA_W-1:0]   mem_rdata,
    input  logic [NUM_PORTS-1:0]          mem_ack
);

    logic [NUM_PORTS-1:0]            mmr_req;
    logic [NUM_PORTS-1:0]            mmr_gnt;
    logic                            mmr_last;
    logic [NUM_PORTS-1:0]            mmr_we_v;
    logic [NUM_PORTS*MMR_ADDR_W-1:0] mmr_addr_v;
    logic [NUM_PORTS*DATA_W-1:0]     mmr_wdata_v;

    mmr_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .LATENCY   (MMR_LATENCY)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (mmr_req),
        .gnt_c  (mmr_gnt),
        .last_c (mmr_last)
    );

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        port_state_e            state_q, state_d;
        logic                   we_q, we_d;
        logic [ADDR_W-1:0]      addr_q, addr_d;
        logic [DATA_W-1:0]      wdata_q, wdata_d;
        logic [DATA_W-1:0]      rdata_q, rdata_d;
        logic                   err_q, err_d;
        logic [TIMEOUT_W-1:0]   tcnt_q, tcnt_d;
        logic [ADDR_W-1:0]      req_addr;
        logic                   is_mmr;
        logic                   rda_c, err_c, men_c, mwe_c;
        logic [DATA_W-1:0]      rdata_c, mwdata_c;
        logic [ADDR_W-1:0]      maddr_c;

        assign req_addr = `MMR_PORT_SLICE(cpu_addr, i, ADDR_W);
        assign is_mmr   = &req_addr[ADDR_W-1 -: MMR_PREFIX_BITS];

        // Port state and captured transaction registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                we_q    <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
                rdata_q <= '0;
                err_q   <= 1'b0;
                tcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                we_q    <= we_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                rdata_q <= rdata_d;
                err_q   <= err_d;
                tcnt_q  <= tcnt_d;
            end
        end

        // Next state: accept in IDLE only, then run the MMR or memory handshake.
        always_comb begin
            state_d = state_q;
            we_d    = we_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            rdata_d = rdata_q;
            err_d   = err_q;
            tcnt_d  = tcnt_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (cpu_req[i]) begin
                        we_d    = cpu_we[i];
                        addr_d  = req_addr;
                        wdata_d = `MMR_PORT_SLICE(cpu_wdata, i, DATA_W);
                        rdata_d = '0;
                        err_d   = 1'b0;
                        tcnt_d  = '0;
                        state_d = is_mmr ? ST_MMR_ARB : ST_MEM_REQ;
                    end
                end
                ST_MMR_ARB: begin
                    if (mmr_gnt[i]) begin
                        if (MMR_LATENCY == 1) begin
                            rdata_d = we_q ? '0 : mmr_rdata;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_MMR_WAIT;
                        end
                    end
                end
                ST_MMR_WAIT: begin
                    if (mmr_last) begin
                        rdata_d = we_q ? '0 : mmr_rdata;
                        state_d = ST_DONE;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_ack[i]) begin
                        rdata_d = we_q ? '0 : `MMR_PORT_SLICE(mem_rdata, i, DATA_W);
                        state_d = ST_DONE;
                    end else if (tcnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        tcnt_d = tcnt_q + TIMEOUT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Port outputs decoded from registered state; zero outside their phase.
        always_comb begin
            rda_c    = (state_q == ST_DONE);
            rdata_c  = rda_c ? rdata_q : '0;
            err_c    = rda_c & err_q;
            men_c    = (state_q == ST_MEM_REQ);
            mwe_c    = men_c & we_q;
            maddr_c  = men_c ? addr_q : '0;
            mwdata_c = men_c ? wdata_q : '0;
        end

        assign cpu_rda[i]                              = rda_c;
        assign cpu_err[i]                              = err_c;
        assign `MMR_PORT_SLICE(cpu_rdata, i, DATA_W)   = rdata_c;
        assign mem_en[i]                               = men_c;
        assign mem_we[i]                               = mwe_c;
        assign `MMR_PORT_SLICE(mem_addr, i, ADDR_W)    = maddr_c;
        assign `MMR_PORT_SLICE(mem_wdata, i, DATA_W)   = mwdata_c;

        assign mmr_req[i]                                  = (state_q == ST_MMR_ARB);
        assign mmr_we_v[i]                                 = mmr_gnt[i] & we_q;
        assign `MMR_PORT_SLICE(mmr_addr_v, i, MMR_ADDR_W)  = mmr_gnt[i] ? addr_q[MMR_ADDR_W-1:0] : '0;
        assign `MMR_PORT_SLICE(mmr_wdata_v, i, DATA_W)     = mmr_gnt[i] ? wdata_q : '0;
    end

    // MMR bus driven by the granted port; the one-hot grant makes OR a mux.
    always_comb begin
        mmr_en    = |mmr_gnt;
        mmr_we    = |mmr_we_v;
        mmr_addr  = '0;
        mmr_wdata = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            mmr_addr  = mmr_addr  | mmr_addr_v[p*MMR_ADDR_W +: MMR_ADDR_W];
            mmr_wdata = mmr_wdata | mmr_wdata_v[p*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_mmr_mem_router.sv
// Directed bench for mmr_mem_router: two ports, MMR_LATENCY=1, TIMEOUT=8.
module tb_mmr_mem_router;

    logic        clk;
    logic        rst;
    logic [1:0]  cpu_req;
    logic [1:0]  cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;
    logic [1:0]  cpu_rda;
    logic [1:0]  cpu_err;
    logic        mmr_en;
    logic        mmr_we;
    logic [7:0]  mmr_addr;
    logic [31:0] mmr_wdata;
    logic [31:0] mmr_rdata;
    logic [1:0]  mem_en;
    logic [1:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_ack;

    int errors;
    int checks;

    mmr_mem_router #(
        .NUM_PORTS   (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .MMR_LATENCY (1),
        .TIMEOUT     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rda   (cpu_rda),
        .cpu_err   (cpu_err),
        .mmr_en    (mmr_en),
        .mmr_we    (mmr_we),
        .mmr_addr  (mmr_addr),
        .mmr_wdata (mmr_wdata),
        .mmr_rdata (mmr_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        mmr_rdata = '0; mem_rdata = '0; mem_ack = '0;
        repeat (3) tick();
        checks++; if ({cpu_rda, cpu_err, mmr_en, mmr_we, mem_en, mem_we} !== 10'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0", {cpu_rda, cpu_err, mmr_en, mmr_we, mem_en, mem_we}); end
        checks++; if ({cpu_rdata, mem_addr, mem_wdata, mmr_addr, mmr_wdata} !== '0) begin
            errors++; $display("FAIL reset_data: nonzero data outputs"); end
        rst = 1'b0;
        tick();
        checks++; if ({cpu_rda, mmr_en, mem_en} !== 5'b0) begin
            errors++; $display("FAIL reset_release: got %b want 0", {cpu_rda, mmr_en, mem_en}); end
    endtask

    task automatic test_mmr_read();
        cpu_req = 2'b01; cpu_we = 2'b00; cpu_addr[31:0] = 32'hFFF8_0010; mmr_rdata = 32'hA5A5_A5A5;
        tick(); // A+1
        cpu_req = 2'b00;
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'h10 || mmr_we !== 1'b0) begin
            errors++; $display("FAIL mmr_rd_strobe: en=%b addr=%h we=%b want 1/10/0", mmr_en, mmr_addr, mmr_we); end
        checks++; if (cpu_rda !== 2'b00 || mem_en !== 2'b00) begin
            errors++; $display("FAIL mmr_rd_early: rda=%b mem_en=%b want 00/00", cpu_rda, mem_en); end
        tick(); // A+2
        checks++; if (cpu_rda !== 2'b01 || cpu_rdata !== 64'h0000_0000_A5A5_A5A5) begin
            errors++; $display("FAIL mmr_rd_done: rda=%b rdata=%h want 01/00000000a5a5a5a5", cpu_rda, cpu_rdata); end
        checks++; if (cpu_err !== 2'b00 || mmr_en !== 1'b0 || mem_en !== 2'b00) begin
            errors++; $display("FAIL mmr_rd_others: err=%b mmr_en=%b mem_en=%b want 0", cpu_err, mmr_en, mem_en); end
        tick(); // A+3
        checks++; if (cpu_rda !== 2'b00 || cpu_rdata !== 64'h0) begin
            errors++; $display("FAIL mmr_rd_pulse: rda=%b rdata=%h want 0", cpu_rda, cpu_rdata); end
    endtask

    task automatic test_mmr_contention();
        do_reset();
        cpu_req = 2'b11; cpu_we = 2'b00;
        cpu_addr = {32'hFFF8_0030, 32'hFFF8_0020};
        tick(); // A+1: port0 wins after reset
        cpu_req = 2'b00;
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'h20) begin
            errors++; $display("FAIL arb_first: en=%b addr=%h want 1/20", mmr_en, mmr_addr); end
        mmr_rdata = 32'h1111_1111;
        tick(); // A+2
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'h30) begin
            errors++; $display("FAIL arb_second: en=%b addr=%h want 1/30", mmr_en, mmr_addr); end
        checks++; if (cpu_rda !== 2'b01 || cpu_rdata[31:0] !== 32'h1111_1111) begin
            errors++; $display("FAIL arb_rda0: rda=%b rdata=%h want 01/11111111", cpu_rda, cpu_rdata[31:0]); end
        mmr_rdata = 32'h2222_2222;
        tick(); // A+3
        checks++; if (cpu_rda !== 2'b10 || cpu_rdata[63:32] !== 32'h2222_2222 || mmr_en !== 1'b0) begin
            errors++; $display("FAIL arb_rda1: rda=%b rdata=%h en=%b want 10/22222222/0", cpu_rda, cpu_rdata[63:32], mmr_en); end
        tick();
        // A lone port0 access moves the pointer to port0, so port1 leads next time.
        cpu_req = 2'b01;
        tick();
        cpu_req = 2'b00;
        tick();
        tick();
        cpu_req = 2'b11;
        tick(); // A+1
        cpu_req = 2'b00;
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'h30) begin
            errors++; $display("FAIL arb_rotate1: en=%b addr=%h want 1/30", mmr_en, mmr_addr); end
        tick(); // A+2
        checks++; if (mmr_addr !== 8'h20 || cpu_rda !== 2'b10) begin
            errors++; $display("FAIL arb_rotate2: addr=%h rda=%b want 20/10", mmr_addr, cpu_rda); end
        tick(); // A+3
        checks++; if (cpu_rda !== 2'b01) begin
            errors++; $display("FAIL arb_rotate3: rda=%b want 01", cpu_rda); end
        tick();
    endtask

    task automatic test_mem_write();
        bit mmr_seen;
        bit stable_ok;
        mmr_seen = 1'b0;
        stable_ok = 1'b1;
        cpu_req = 2'b10; cpu_we = 2'b10;
        cpu_addr[63:32] = 32'h0000_1000; cpu_wdata[63:32] = 32'h1234_5678;
        mem_rdata[63:32] = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            tick(); // A+c
            cpu_req = 2'b00; cpu_wdata[63:32] = 32'h0;
            mmr_seen = mmr_seen | mmr_en;
            if (mem_en !== 2'b10 || mem_we !== 2'b10 || mem_addr[63:32] !== 32'h0000_1000
                || mem_wdata[63:32] !== 32'h1234_5678 || cpu_rda !== 2'b00) stable_ok = 1'b0;
            if (c == 3) mem_ack = 2'b10;
        end
        checks++; if (stable_ok !== 1'b1) begin
            errors++; $display("FAIL mem_wr_hold: en=%b we=%b addr=%h wdata=%h", mem_en, mem_we, mem_addr[63:32], mem_wdata[63:32]); end
        tick(); // A+4
        mem_ack = 2'b00;
        mmr_seen = mmr_seen | mmr_en;
        checks++; if (mem_en !== 2'b00 || cpu_rda !== 2'b10 || cpu_err !== 2'b00 || cpu_rdata !== 64'h0) begin
            errors++; $display("FAIL mem_wr_done: en=%b rda=%b err=%b rdata=%h want 00/10/00/0", mem_en, cpu_rda, cpu_err, cpu_rdata); end
        tick();
        checks++; if (mmr_seen !== 1'b0 || cpu_rda !== 2'b00) begin
            errors++; $display("FAIL mem_wr_quiet: mmr_seen=%b rda=%b want 0/00", mmr_seen, cpu_rda); end
        cpu_we = 2'b00;
    endtask

    task automatic test_timeout();
        int en_cycles;
        en_cycles = 0;
        cpu_req = 2'b01; cpu_we = 2'b00; cpu_addr[31:0] = 32'h0000_2000;
        mem_rdata[31:0] = 32'hCAFE_F00D;
        for (int c = 1; c <= 8; c++) begin
            tick();
            cpu_req = 2'b00;
            if (mem_en === 2'b01) en_cycles++;
        end
        checks++; if (en_cycles != 8) begin
            errors++; $display("FAIL timeout_len: got %0d cycles want 8", en_cycles); end
        tick(); // A+9
        checks++; if (mem_en !== 2'b00 || cpu_rda !== 2'b01 || cpu_err !== 2'b01 || cpu_rdata !== 64'h0) begin
            errors++; $display("FAIL timeout_done: en=%b rda=%b err=%b rdata=%h want 00/01/01/0", mem_en, cpu_rda, cpu_err, cpu_rdata); end
        tick();
        checks++; if (cpu_rda !== 2'b00 || cpu_err !== 2'b00) begin
            errors++; $display("FAIL timeout_pulse: rda=%b err=%b want 00/00", cpu_rda, cpu_err); end
    endtask

    task automatic test_async_reset();
        cpu_req = 2'b01; cpu_we = 2'b00; cpu_addr[31:0] = 32'h0000_4000;
        tick();
        cpu_req = 2'b00;
        tick();
        checks++; if (mem_en !== 2'b01 || mem_addr[31:0] !== 32'h0000_4000) begin
            errors++; $display("FAIL arst_pre: en=%b addr=%h want 01/00004000", mem_en, mem_addr[31:0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_en !== 2'b00 || mem_addr !== 64'h0 || cpu_rda !== 2'b00 || mmr_en !== 1'b0) begin
            errors++; $display("FAIL arst_now: en=%b addr=%h rda=%b want 0", mem_en, mem_addr, cpu_rda); end
        tick();
        rst = 1'b0;
        mem_ack = 2'b01;
        tick();
        mem_ack = 2'b00;
        checks++; if (cpu_rda !== 2'b00 || mem_en !== 2'b00) begin
            errors++; $display("FAIL arst_stale_ack: rda=%b en=%b want 00/00", cpu_rda, mem_en); end
        tick();
        checks++; if (cpu_rda !== 2'b00) begin
            errors++; $display("FAIL arst_stale_rda: rda=%b want 00", cpu_rda); end
        cpu_req = 2'b01; cpu_addr[31:0] = 32'hFFF8_00A0; mmr_rdata = 32'h7777_0001;
        tick();
        cpu_req = 2'b00;
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'hA0) begin
            errors++; $display("FAIL arst_next_en: en=%b addr=%h want 1/a0", mmr_en, mmr_addr); end
        tick();
        checks++; if (cpu_rda !== 2'b01 || cpu_rdata[31:0] !== 32'h7777_0001) begin
            errors++; $display("FAIL arst_next_rda: rda=%b rdata=%h want 01/77770001", cpu_rda, cpu_rdata[31:0]); end
        tick();
    endtask

    task automatic test_concurrent();
        cpu_req = 2'b11; cpu_we = 2'b00;
        cpu_addr = {32'h0000_3000, 32'hFFF8_0044};
        mem_rdata[63:32] = 32'h0BAD_F00D; mmr_rdata = 32'h5A5A_0000;
        tick(); // A+1
        cpu_req = 2'b01; // port0 keeps requesting through its busy states
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'h44 || mem_en !== 2'b10) begin
            errors++; $display("FAIL conc_start: mmr_en=%b addr=%h mem_en=%b want 1/44/10", mmr_en, mmr_addr, mem_en); end
        tick(); // A+2
        checks++; if (cpu_rda !== 2'b01 || cpu_rdata[31:0] !== 32'h5A5A_0000 || mem_en !== 2'b10 || mmr_en !== 1'b0) begin
            errors++; $display("FAIL conc_mmr_done: rda=%b rdata=%h mem_en=%b mmr_en=%b", cpu_rda, cpu_rdata[31:0], mem_en, mmr_en); end
        mem_ack = 2'b10;
        tick(); // A+3
        mem_ack = 2'b00;
        checks++; if (cpu_rda !== 2'b10 || cpu_rdata[63:32] !== 32'h0BAD_F00D || cpu_err !== 2'b00) begin
            errors++; $display("FAIL conc_mem_done: rda=%b rdata=%h err=%b want 10/0badf00d/00", cpu_rda, cpu_rdata[63:32], cpu_err); end
        checks++; if (mem_en !== 2'b00 || mmr_en !== 1'b0) begin
            errors++; $display("FAIL conc_held_req: mem_en=%b mmr_en=%b want 00/0", mem_en, mmr_en); end
        tick(); // A+4: held request accepted in A+3 (first IDLE cycle)
        cpu_req = 2'b00;
        checks++; if (mmr_en !== 1'b1 || mmr_addr !== 8'h44) begin
            errors++; $display("FAIL conc_reaccept: en=%b addr=%h want 1/44", mmr_en, mmr_addr); end
        mmr_rdata = 32'h00C0_FFEE;
        tick(); // A+5
        checks++; if (cpu_rda !== 2'b01 || cpu_rdata[31:0] !== 32'h00C0_FFEE) begin
            errors++; $display("FAIL conc_second_rda: rda=%b rdata=%h want 01/00c0ffee", cpu_rda, cpu_rdata[31:0]); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mmr_read();
        test_mmr_contention();
        test_mem_write();
        test_timeout();
        test_async_reset();
        test_concurrent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
